// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/return sequencer beside the CSR file in EX.
// Serialises the trap-entry CSR writes (MEPC, MCAUSE, MTVAL, MSTATUS) and the
// MRET MSTATUS restore through the CSR file's single write port, then issues a
// one-cycle fetch redirect. Owns priv_mode and arbitrates the write port with EX.
// Optional feature: define VECTORED_INT_EN to enable vectored interrupt targets
// (mtvec[1:0]==01 and cause[31]==1 -> base + cause*4); otherwise target = base.
module trap_ctrl #(
  parameter logic [1:0]  RESET_PRIV  = 2'b11,
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_csr_we,
  input  logic [11:0] ex_csr_waddr,
  input  logic [31:0] ex_csr_wdata,
  output logic        ex_stall,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  priv_mode,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] ALIGN_MASK = (32'd1 << MTVEC_ALIGN) - 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STAT,
    R_STAT,
    REDIR
  } state_t;

  state_t      state;
  logic [31:0] lat_pc;     // trap PC, or MEPC for an MRET
  logic [31:0] lat_cause;
  logic [31:0] lat_tval;
  logic [31:0] lat_st;     // MSTATUS snapshot at acceptance
  logic [31:0] lat_mtvec;
  logic [1:0]  lat_priv;   // privilege the trap was taken from

  logic [31:0] base;
  logic [31:0] trap_target;
  logic [31:0] stat_trap;
  logic [31:0] stat_mret;

  // Trap target and the two MSTATUS rewrite values, all from latched state
  always_comb begin
    base = lat_mtvec & ~ALIGN_MASK;
`ifdef VECTORED_INT_EN
    if (lat_mtvec[1:0] == 2'b01 && lat_cause[31])
      trap_target = base + {lat_cause[29:0], 2'b00};
    else
      trap_target = base;
`else
    trap_target = base;
`endif
    stat_trap        = lat_st;
    stat_trap[12:11] = lat_priv;
    stat_trap[7]     = lat_st[3];
    stat_trap[3]     = 1'b0;
    stat_mret        = lat_st;
    stat_mret[3]     = lat_st[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = 2'b00;
  end

  // Sequencer: request acceptance, latching, privilege and redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      priv_mode    <= RESET_PRIV;
      lat_pc       <= '0;
      lat_cause    <= '0;
      lat_tval     <= '0;
      lat_st       <= '0;
      lat_mtvec    <= '0;
      lat_priv     <= '0;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      redirect_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (trap_req) begin
            lat_pc    <= trap_pc;
            lat_cause <= trap_cause;
            lat_tval  <= trap_tval;
            lat_st    <= csr_mstatus;
            lat_mtvec <= csr_mtvec;
            lat_priv  <= priv_mode;
            priv_mode <= 2'b11;
            state     <= T_EPC;
          end else if (mret_req) begin
            lat_st <= csr_mstatus;
            lat_pc <= csr_mepc;
            state  <= R_STAT;
          end
        end
        T_EPC:   state <= T_CAUSE;
        T_CAUSE: state <= T_TVAL;
        T_TVAL:  state <= T_STAT;
        T_STAT: begin
          redirect_vld <= 1'b1;
          redirect_pc  <= trap_target;
          state        <= REDIR;
        end
        R_STAT: begin
          priv_mode    <= lat_st[12:11];
          redirect_vld <= 1'b1;
          redirect_pc  <= lat_pc;
          state        <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-port mux: EX pass-through in IDLE, sequencer writes otherwise
  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    case (state)
      IDLE: begin
        // a trap in the same cycle flushes the EX instruction
        csr_we    = ex_csr_we & ~trap_req;
        csr_waddr = ex_csr_waddr;
        csr_wdata = ex_csr_wdata;
      end
      T_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = lat_pc;
      end
      T_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = lat_cause;
      end
      T_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = lat_tval;
      end
      T_STAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = stat_trap;
      end
      R_STAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = stat_mret;
      end
      default: ;
    endcase
    if (rst) csr_we = 1'b0;
  end

  // Status outputs
  always_comb begin
    ex_stall = (state != IDLE);
    busy     = (state != IDLE) && !rst;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vectors with hand-computed expectations for trap_ctrl.
// Inputs are driven just after the falling edge and outputs checked 1 ns later.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_csr_we;
  logic [11:0] ex_csr_waddr;
  logic [31:0] ex_csr_wdata;
  logic        ex_stall;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  priv_mode;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  trap_ctrl #(.RESET_PRIV(2'b11), .MTVEC_ALIGN(2)) dut (
    .clk(clk), .rst(rst),
    .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
    .ex_stall(ex_stall),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req),
    .csr_mtvec(csr_mtvec), .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .priv_mode(priv_mode),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance to the next drive point (just after the falling edge)
  task automatic next;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    check({tag, ".we"},   {31'd0, csr_we},     32'd1);
    check({tag, ".addr"}, {20'd0, csr_waddr},  {20'd0, addr});
    check({tag, ".data"}, csr_wdata,           data);
    check({tag, ".stall"},{31'd0, ex_stall},   32'd1);
  endtask

  initial begin
    rst = 1'b1;
    ex_csr_we = 1'b1; ex_csr_waddr = 12'h180; ex_csr_wdata = 32'h1111_2222;
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret_req = 1'b0; csr_mtvec = '0; csr_mstatus = '0; csr_mepc = '0;

    // reset held two cycles, EX write request active throughout
    next; settle;
    check("rst.csr_we_during", {31'd0, csr_we}, 32'd0);
    check("rst.busy_during",   {31'd0, busy},   32'd0);
    next; rst = 1'b0; ex_csr_we = 1'b0; settle;
    check("rst.priv",   {30'd0, priv_mode},    32'h3);
    check("rst.busy",   {31'd0, busy},         32'd0);
    check("rst.csr_we", {31'd0, csr_we},       32'd0);
    check("rst.rvld",   {31'd0, redirect_vld}, 32'd0);
    check("rst.rpc",    redirect_pc,           32'd0);

    // EX pass-through of a SATP write
    next; ex_csr_we = 1'b1; ex_csr_waddr = 12'h180; ex_csr_wdata = 32'h8000_0001; settle;
    check("pass.we",    {31'd0, csr_we},      32'd1);
    check("pass.addr",  {20'd0, csr_waddr},   32'h180);
    check("pass.data",  csr_wdata,            32'h8000_0001);
    check("pass.stall", {31'd0, ex_stall},    32'd0);

    // MRET: mstatus=0x880 (MPP=01, MPIE=1), mepc=0x2000
    next; ex_csr_we = 1'b0; mret_req = 1'b1; csr_mstatus = 32'h0000_0880; csr_mepc = 32'h2000; settle;
    check("mret.T.busy", {31'd0, busy}, 32'd0);
    next; mret_req = 1'b0; csr_mstatus = 32'hFFFF_FFFF; csr_mepc = 32'h0; settle;
    check_write("mret.T1", 12'h300, 32'h0000_0088);
    check("mret.T1.priv", {30'd0, priv_mode}, 32'h3);
    next; settle;
    check("mret.T2.rvld", {31'd0, redirect_vld}, 32'd1);
    check("mret.T2.rpc",  redirect_pc,           32'h2000);
    check("mret.T2.priv", {30'd0, priv_mode},    32'h1);
    check("mret.T2.we",   {31'd0, csr_we},       32'd0);
    next; settle;
    check("mret.T3.rvld", {31'd0, redirect_vld}, 32'd0);
    check("mret.T3.rpc",  redirect_pc,           32'h2000);
    check("mret.T3.busy", {31'd0, busy},         32'd0);

    // Trap from S-mode with a colliding EX write that must be dropped
    next; trap_req = 1'b1; trap_pc = 32'h1234; trap_cause = 32'hD; trap_tval = 32'hDEAD_0000;
    csr_mtvec = 32'h8000_0100; csr_mstatus = 32'h0000_0008;
    ex_csr_we = 1'b1; ex_csr_waddr = 12'h180; ex_csr_wdata = 32'h5; settle;
    check("trap.T.flush", {31'd0, csr_we}, 32'd0);
    next; trap_req = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0;
    csr_mtvec = 32'h0; csr_mstatus = 32'hFFFF_FFFF; settle;
    check_write("trap.T1", 12'h341, 32'h1234);
    check("trap.T1.priv", {30'd0, priv_mode}, 32'h3);
    next; settle; check_write("trap.T2", 12'h342, 32'hD);
    next; settle; check_write("trap.T3", 12'h343, 32'hDEAD_0000);
    next; settle; check_write("trap.T4", 12'h300, 32'h0000_0880);
    check("trap.T4.rvld", {31'd0, redirect_vld}, 32'd0);
    next; settle;
    check("trap.T5.rvld",  {31'd0, redirect_vld}, 32'd1);
    check("trap.T5.rpc",   redirect_pc,           32'h8000_0100);
    check("trap.T5.stall", {31'd0, ex_stall},     32'd1);
    check("trap.T5.we",    {31'd0, csr_we},       32'd0);
    next; ex_csr_we = 1'b0; settle;
    check("trap.T6.rvld", {31'd0, redirect_vld}, 32'd0);
    check("trap.T6.busy", {31'd0, busy},         32'd0);

    // Vectored interrupt candidate: mtvec mode 01, interrupt cause 7, from M
    next; trap_req = 1'b1; trap_pc = 32'h400; trap_cause = 32'h8000_0007; trap_tval = 32'h0;
    csr_mtvec = 32'h8000_0101; csr_mstatus = 32'h0; settle;
    next; trap_req = 1'b0; settle;
    next; settle; check_write("vec.T2", 12'h342, 32'h8000_0007);
    next; settle;
    next; settle; check_write("vec.T4", 12'h300, 32'h0000_1800);
    next; settle;
    check("vec.T5.rvld", {31'd0, redirect_vld}, 32'd1);
`ifdef VECTORED_INT_EN
    check("vec.T5.rpc", redirect_pc, 32'h8000_011C);
`else
    check("vec.T5.rpc", redirect_pc, 32'h8000_0100);
`endif

    // trap_req + mret_req together: trap wins; mtvec mode bits 11 masked off
    next; settle;
    next; trap_req = 1'b1; mret_req = 1'b1; trap_pc = 32'h600; trap_cause = 32'h2; trap_tval = 32'h0;
    csr_mtvec = 32'h0000_0203; csr_mstatus = 32'h0; csr_mepc = 32'h4444; settle;
    next; trap_req = 1'b0; mret_req = 1'b0; settle;
    check_write("coll.T1", 12'h341, 32'h600);
    next; settle; next; settle; next; settle;
    check_write("coll.T4", 12'h300, 32'h0000_1800);
    next; settle;
    check("coll.T5.rvld", {31'd0, redirect_vld}, 32'd1);
    check("coll.T5.rpc",  redirect_pc,           32'h0000_0200);
    check("coll.T5.priv", {30'd0, priv_mode},    32'h3);
    next; settle;
    check("coll.T6.busy", {31'd0, busy}, 32'd0);

    // Abort: reset during T_CAUSE
    next; trap_req = 1'b1; trap_pc = 32'h800; trap_cause = 32'h5; csr_mtvec = 32'h3000; settle;
    next; trap_req = 1'b0; settle;
    check_write("abort.T1", 12'h341, 32'h800);
    next; rst = 1'b1; settle;
    check("abort.T2.we",   {31'd0, csr_we}, 32'd0);
    check("abort.T2.busy", {31'd0, busy},   32'd0);
    next; rst = 1'b0; settle;
    check("abort.T3.busy", {31'd0, busy},         32'd0);
    check("abort.T3.priv", {30'd0, priv_mode},    32'h3);
    check("abort.T3.rpc",  redirect_pc,           32'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      next; settle;
      check("abort.no_rvld", {31'd0, redirect_vld}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
